usb_uart_word_buffer: RTL and testbench
=======================================

# usb_uart_word_buffer

Parametrised buffering and width-adaptation stage between user logic and the byte-wide `usb_uart` pipelines. It accepts multi-byte words from user logic into a TX FIFO, serialises each word LSB-byte-first onto the `uart_in_*` byte pipeline, and assembles bytes from the `uart_out_*` pipeline into words held in an RX FIFO. It sits directly beside the `usb_uart` instance in the same `clk_48mhz` domain. Both FIFO depths and the word width are set at elaboration.

## Interface
- `WORD_BYTES`, default 2: bytes per user word, range 1..8; word width `W = 8*WORD_BYTES`.
- `TX_DEPTH`, default 16: TX FIFO depth in words, power of two, at least 2.
- `RX_DEPTH`, default 16: RX FIFO depth in words, power of two, at least 2.

- `clk_48mhz` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `tx_data` in W: word from user logic.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: equals TX FIFO not full.
- `rx_data` out W: assembled word, head of the RX FIFO.
- `rx_valid` out 1: equals RX FIFO not empty.
- `rx_ready` in 1: user accepts `rx_data`.
- `rx_flush` in 1: synchronous clear of the RX FIFO and the partial-word assembler.
- `uart_in_data` out 8: byte toward the host, drives `usb_uart` `uart_in_data`.
- `uart_in_valid` out 1: byte toward the host is valid.
- `uart_in_ready` in 1: from `usb_uart`.
- `uart_out_data` in 8: byte from the host.
- `uart_out_valid` in 1: byte from the host is valid.
- `uart_out_ready` out 1: to `usb_uart`; equals RX FIFO not full and `rx_flush` low.
- `tx_level` out clog2(TX_DEPTH)+1: number of words in the TX FIFO.
- `rx_level` out clog2(RX_DEPTH)+1: number of words in the RX FIFO.

## Operation
- A handshake is `valid & ready` sampled at the rising edge of `clk_48mhz`.
- **TX FIFO**
  - Pushes on a `tx` handshake.
  - Pops when the serialiser loads a word.
  - A simultaneous push and pop leaves `tx_level` unchanged.
- **Serialiser FSM** has two states, IDLE and SEND, plus a byte index `bi` running 0..WORD_BYTES-1.
  - IDLE: if the TX FIFO is non-empty, load the head word into the shift register, pop the FIFO, set `bi=0`, go to SEND.
  - SEND: `uart_in_valid=1` and `uart_in_data` = byte `bi` of the shift register (byte 0 = bits 7:0).
  - On a `uart_in` handshake with `bi<WORD_BYTES-1`: increment `bi`.
  - On a `uart_in` handshake with `bi=WORD_BYTES-1`: if the TX FIFO is non-empty, load the next word in the same edge (no bubble) and stay in SEND; otherwise go to IDLE.
  - `uart_in_data` is held stable while `uart_in_valid` is high and `uart_in_ready` is low.
- **Assembler**
  - Each `uart_out` handshake writes the byte into lane `ai`, where `ai` is a byte counter.
  - When `ai=WORD_BYTES-1`, the completed word (including the current byte) is pushed to the RX FIFO and `ai` returns to 0.
  - With `WORD_BYTES=1`, every byte pushes a word.
- **RX FIFO**
  - Pops on an `rx` handshake.
  - Simultaneous push and pop is allowed.
  - Overflow cannot occur, because `uart_out_ready` is low whenever the FIFO is full.
- **`rx_flush`**: in the cycle it is high, the RX FIFO empties (`rx_level` becomes 0), `ai` becomes 0, and no byte is accepted. The TX path is unaffected.
- **Reset values**: `tx_ready=1`, `rx_valid=0`, `uart_in_valid=0`, `uart_in_data=0`, `uart_out_ready=1`, `rx_data=0`, both levels 0, FSM in IDLE, `bi=ai=0`.
- **Reset asserted mid-word**: all state clears immediately. A partially sent word is lost. The host may receive a truncated word; that is acceptable.

## Timing
- TX latency: a `tx` handshake at edge k into an empty FIFO gives `uart_in_valid=1` after edge k+1, with byte 0 presented.
- TX throughput: with `uart_in_ready` held high, one byte is sent per cycle, continuous across word boundaries.
- RX latency: the final byte's handshake at edge k gives `rx_valid=1` and the valid word on `rx_data` after edge k. `rx_data` shows the FIFO head with no read latency.
- Full/empty flags and levels are registered and update on the edge of the push or pop that changes them.
- All outputs change only on `clk_48mhz` edges or on reset assertion.

## Configuration
- Macro: `USB_UART_WORD_BUFFER_STATS_EN`.
- When defined, three extra outputs are added:
  - `tx_byte_count` (16 bits): counts `uart_in` handshakes.
  - `rx_byte_count` (16 bits): counts `uart_out` handshakes.
  - `rx_drop_count` (8 bits): counts `uart_out_valid` cycles in which `uart_out_ready` was low.
- All three counters wrap modulo 2^N, clear on reset, and `rx_drop_count` also clears on `rx_flush`.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

## Test plan
- **Basic TX ordering**: `WORD_BYTES=2`; push 0xA1B2 then 0xC3D4 with `uart_in_ready=1` → `uart_in` bytes B2, A1, D4, C3 on 4 consecutive cycles, first one 1 cycle after the push edge.
- **RX assembly**: send bytes 11, 22, 33, 44 on `uart_out`, `rx_ready=0` → `rx_level=2`; pops yield 0x2211 then 0x4433.
- **Backpressure and full**: `RX_DEPTH=2`, `rx_ready=0`, stream 6 bytes → `uart_out_ready` goes low after the 4th byte and stays low; the 5th byte is not accepted until a pop, after which `uart_out_ready=1` the next cycle.
- **TX stall**: toggle `uart_in_ready` in the pattern 1,0,0,1 during a word → `uart_in_data` holds stable during the stall; `tx_level` goes 16→15 on load and `tx_ready` returns high.
- **Flush and reset**: send 1 byte (partial word), pulse `rx_flush`, then send 0x55, 0x66 → `rx_data=0x6655`. Assert `reset` mid-SEND → `uart_in_valid=0` immediately and levels read 0.
- **Stats build** (macro defined): after the first two scenarios → `tx_byte_count=4`, `rx_byte_count=4`, `rx_drop_count=0`.

Source files
------------

// File: rtl/usb_uart_word_buffer_if.sv
// -----------------------------------------------------------------------------
// usb_uart_word_buffer_if
// Bundles the user-side word handshakes, the byte-wide usb_uart pipelines
// and the FIFO level outputs of usb_uart_word_buffer.
//   slave  : the buffer's view (drives tx_ready, rx_*, uart_in_*,
//            uart_out_ready and the levels)
//   master : the surrounding logic's view (drives tx_data/valid, rx_ready,
//            rx_flush, uart_in_ready, uart_out_data/valid)
// Parameters must match those of the usb_uart_word_buffer instance.
// -----------------------------------------------------------------------------
interface usb_uart_word_buffer_if #(
    parameter int WORD_BYTES = 2,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
);
    localparam int W   = 8 * WORD_BYTES;
    localparam int TXL = $clog2(TX_DEPTH) + 1;
    localparam int RXL = $clog2(RX_DEPTH) + 1;

    // User word interface
    logic [W-1:0]   tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [W-1:0]   rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic           rx_flush;

    // Byte pipelines shared with usb_uart
    logic [7:0]     uart_in_data;
    logic           uart_in_valid;
    logic           uart_in_ready;
    logic [7:0]     uart_out_data;
    logic           uart_out_valid;
    logic           uart_out_ready;

    // Occupancy
    logic [TXL-1:0] tx_level;
    logic [RXL-1:0] rx_level;

    modport slave (
        input  tx_data, tx_valid, rx_ready, rx_flush,
        input  uart_in_ready, uart_out_data, uart_out_valid,
        output tx_ready, rx_data, rx_valid,
        output uart_in_data, uart_in_valid, uart_out_ready,
        output tx_level, rx_level
    );

    modport master (
        output tx_data, tx_valid, rx_ready, rx_flush,
        output uart_in_ready, uart_out_data, uart_out_valid,
        input  tx_ready, rx_data, rx_valid,
        input  uart_in_data, uart_in_valid, uart_out_ready,
        input  tx_level, rx_level
    );
endinterface

// File: rtl/usb_uart_word_buffer.sv
// -----------------------------------------------------------------------------
// usb_uart_word_buffer
// Word buffer / width adapter beside usb_uart in the clk_48mhz domain.
//   TX: user words -> TX FIFO -> serialiser (LSB byte first) -> uart_in_*
//   RX: uart_out_* bytes -> assembler -> RX FIFO -> user words
// Ports:
//   clk_48mhz : sole clock
//   reset     : asynchronous, active-high reset
//   bus       : usb_uart_word_buffer_if.slave (handshakes, flush, levels)
// Optional statistics (macro USB_UART_WORD_BUFFER_STATS_EN):
//   tx_byte_count [15:0] : uart_in handshakes
//   rx_byte_count [15:0] : uart_out handshakes
//   rx_drop_count [7:0]  : uart_out_valid cycles refused (cleared by rx_flush)
// -----------------------------------------------------------------------------
module usb_uart_word_buffer #(
    parameter int WORD_BYTES = 2,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic                       clk_48mhz,
    input  logic                       reset,
    usb_uart_word_buffer_if.slave      bus
`ifdef USB_UART_WORD_BUFFER_STATS_EN
    ,
    output logic [15:0]                tx_byte_count,
    output logic [15:0]                rx_byte_count,
    output logic [7:0]                 rx_drop_count
`endif
);
    localparam int W   = 8 * WORD_BYTES;
    localparam int TXA = $clog2(TX_DEPTH);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam int TXL = TXA + 1;
    localparam int RXL = RXA + 1;
    // Byte index width; a single-byte word still gets a 1-bit index
    localparam int BIW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [BIW-1:0] LAST_IDX    = BIW'(WORD_BYTES - 1);
    localparam logic [TXL-1:0] TX_FULL_LVL = TXL'(TX_DEPTH);
    localparam logic [RXL-1:0] RX_FULL_LVL = RXL'(RX_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

    // ---------------- TX FIFO state ----------------
    logic [W-1:0]   tx_mem [TX_DEPTH];
    logic [TXA-1:0] tx_wr_q, tx_wr_d;
    logic [TXA-1:0] tx_rd_q, tx_rd_d;
    logic [TXL-1:0] tx_level_q, tx_level_d;
    logic           tx_full_q, tx_full_d;

    // ---------------- Serialiser state ----------------
    ser_state_t     state_q, state_d;
    logic [BIW-1:0] bi_q, bi_d;
    logic [W-1:0]   shift_q, shift_d;
    logic           in_valid_q, in_valid_d;

    // ---------------- RX path state ----------------
    logic [W-1:0]   rx_mem [RX_DEPTH];
    logic [RXA-1:0] rx_wr_q, rx_wr_d;
    logic [RXA-1:0] rx_rd_q, rx_rd_d;
    logic [RXL-1:0] rx_level_q, rx_level_d;
    logic           rx_full_q, rx_full_d;
    logic           rx_empty_q, rx_empty_d;
    logic [BIW-1:0] ai_q, ai_d;
    logic [W-1:0]   asm_q, asm_d;

    // ---------------- Combinational handshakes ----------------
    logic           tx_push_s;
    logic           tx_load_s;
    logic           in_hs_s;
    logic           bi_last_s;
    logic [W-1:0]   tx_head_s;
    logic           out_ready_s;
    logic           out_hs_s;
    logic           ai_last_s;
    logic           rx_push_s;
    logic           rx_pop_s;
    logic [W-1:0]   word_s;
    logic [W-1:0]   rx_data_s;

    assign tx_push_s   = bus.tx_valid & ~tx_full_q;
    assign in_hs_s     = in_valid_q & bus.uart_in_ready;
    assign bi_last_s   = (bi_q == LAST_IDX);
    assign tx_head_s   = tx_mem[tx_rd_q];
    // Load from IDLE, or back-to-back on the last byte of the current word
    assign tx_load_s   = (tx_level_q != {TXL{1'b0}}) &
                         ((state_q == S_IDLE) | (in_hs_s & bi_last_s));

    // Flush refuses bytes in the same cycle so nothing lands in a cleared FIFO
    assign out_ready_s = ~rx_full_q & ~bus.rx_flush;
    assign out_hs_s    = bus.uart_out_valid & out_ready_s;
    assign ai_last_s   = (ai_q == LAST_IDX);
    assign rx_push_s   = out_hs_s & ai_last_s;
    assign rx_pop_s    = bus.rx_ready & ~rx_empty_q & ~bus.rx_flush;
    // Head word shown with no read latency; zero while empty
    assign rx_data_s   = rx_empty_q ? {W{1'b0}} : rx_mem[rx_rd_q];

    // ---------------- Outputs ----------------
    assign bus.tx_ready       = ~tx_full_q;
    assign bus.tx_level       = tx_level_q;
    assign bus.uart_in_valid  = in_valid_q;
    assign bus.uart_in_data   = shift_q[7:0];
    assign bus.uart_out_ready = out_ready_s;
    assign bus.rx_valid       = ~rx_empty_q;
    assign bus.rx_data        = rx_data_s;
    assign bus.rx_level       = rx_level_q;

    // TX FIFO pointer and occupancy next-state
    always_comb begin
        tx_wr_d    = tx_wr_q;
        tx_rd_d    = tx_rd_q;
        tx_level_d = tx_level_q;
        if (tx_push_s) begin
            tx_wr_d = tx_wr_q + 1'b1;
        end else begin
            tx_wr_d = tx_wr_q;
        end
        if (tx_load_s) begin
            tx_rd_d = tx_rd_q + 1'b1;
        end else begin
            tx_rd_d = tx_rd_q;
        end
        case ({tx_push_s, tx_load_s})
            2'b10:   tx_level_d = tx_level_q + 1'b1;
            2'b01:   tx_level_d = tx_level_q - 1'b1;
            default: tx_level_d = tx_level_q;
        endcase
        tx_full_d = (tx_level_d == TX_FULL_LVL);
    end

    // Serialiser next-state: the shift register presents byte bi on bits 7:0
    always_comb begin
        state_d    = state_q;
        bi_d       = bi_q;
        shift_d    = shift_q;
        in_valid_d = in_valid_q;
        case (state_q)
            S_IDLE: begin
                if (tx_load_s) begin
                    state_d    = S_SEND;
                    bi_d       = {BIW{1'b0}};
                    shift_d    = tx_head_s;
                    in_valid_d = 1'b1;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_SEND: begin
                if (in_hs_s) begin
                    if (tx_load_s) begin
                        state_d    = S_SEND;
                        bi_d       = {BIW{1'b0}};
                        shift_d    = tx_head_s;
                        in_valid_d = 1'b1;
                    end else if (bi_last_s) begin
                        state_d    = S_IDLE;
                        bi_d       = {BIW{1'b0}};
                        shift_d    = shift_q >> 4'd8;
                        in_valid_d = 1'b0;
                    end else begin
                        bi_d       = bi_q + 1'b1;
                        shift_d    = shift_q >> 4'd8;
                    end
                end else begin
                    // Stall: data and valid hold
                    state_d = S_SEND;
                end
            end
            default: begin
                state_d    = S_IDLE;
                bi_d       = {BIW{1'b0}};
                in_valid_d = 1'b0;
            end
        endcase
    end

    // Assembled word including the byte arriving this cycle
    always_comb begin
        word_s = asm_q;
        word_s[{ai_q, 3'b000} +: 8] = bus.uart_out_data;
    end

    // RX FIFO, assembler index and flush next-state
    always_comb begin
        rx_wr_d    = rx_wr_q;
        rx_rd_d    = rx_rd_q;
        rx_level_d = rx_level_q;
        ai_d       = ai_q;
        asm_d      = asm_q;
        if (bus.rx_flush) begin
            rx_wr_d    = {RXA{1'b0}};
            rx_rd_d    = {RXA{1'b0}};
            rx_level_d = {RXL{1'b0}};
            ai_d       = {BIW{1'b0}};
        end else begin
            if (rx_push_s) begin
                rx_wr_d = rx_wr_q + 1'b1;
            end else begin
                rx_wr_d = rx_wr_q;
            end
            if (rx_pop_s) begin
                rx_rd_d = rx_rd_q + 1'b1;
            end else begin
                rx_rd_d = rx_rd_q;
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_level_d = rx_level_q + 1'b1;
                2'b01:   rx_level_d = rx_level_q - 1'b1;
                default: rx_level_d = rx_level_q;
            endcase
            if (out_hs_s) begin
                asm_d = word_s;
                if (ai_last_s) begin
                    ai_d = {BIW{1'b0}};
                end else begin
                    ai_d = ai_q + 1'b1;
                end
            end else begin
                asm_d = asm_q;
                ai_d  = ai_q;
            end
        end
        rx_full_d  = (rx_level_d == RX_FULL_LVL);
        rx_empty_d = (rx_level_d == {RXL{1'b0}});
    end

    // TX FIFO storage (data only, no reset needed)
    always_ff @(posedge clk_48mhz) begin
        if (tx_push_s) begin
            tx_mem[tx_wr_q] <= bus.tx_data;
        end
    end

    // RX FIFO storage (data only; rx_data is masked while empty)
    always_ff @(posedge clk_48mhz) begin
        if (rx_push_s) begin
            rx_mem[rx_wr_q] <= word_s;
        end
    end

    // TX FIFO and serialiser registers
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            tx_wr_q    <= {TXA{1'b0}};
            tx_rd_q    <= {TXA{1'b0}};
            tx_level_q <= {TXL{1'b0}};
            tx_full_q  <= 1'b0;
            state_q    <= S_IDLE;
            bi_q       <= {BIW{1'b0}};
            shift_q    <= {W{1'b0}};
            in_valid_q <= 1'b0;
        end else begin
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            tx_level_q <= tx_level_d;
            tx_full_q  <= tx_full_d;
            state_q    <= state_d;
            bi_q       <= bi_d;
            shift_q    <= shift_d;
            in_valid_q <= in_valid_d;
        end
    end

    // RX FIFO and assembler registers
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            rx_wr_q    <= {RXA{1'b0}};
            rx_rd_q    <= {RXA{1'b0}};
            rx_level_q <= {RXL{1'b0}};
            rx_full_q  <= 1'b0;
            rx_empty_q <= 1'b1;
            ai_q       <= {BIW{1'b0}};
            asm_q      <= {W{1'b0}};
        end else begin
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            rx_level_q <= rx_level_d;
            rx_full_q  <= rx_full_d;
            rx_empty_q <= rx_empty_d;
            ai_q       <= ai_d;
            asm_q      <= asm_d;
        end
    end

`ifdef USB_UART_WORD_BUFFER_STATS_EN
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    assign tx_byte_count = tx_cnt_q;
    assign rx_byte_count = rx_cnt_q;
    assign rx_drop_count = drop_cnt_q;

    // Statistics counters next-state; all wrap naturally
    always_comb begin
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (in_hs_s) begin
            tx_cnt_d = tx_cnt_q + 16'd1;
        end else begin
            tx_cnt_d = tx_cnt_q;
        end
        if (out_hs_s) begin
            rx_cnt_d = rx_cnt_q + 16'd1;
        end else begin
            rx_cnt_d = rx_cnt_q;
        end
        // Flush clears the drop count even though it also refuses the byte
        if (bus.rx_flush) begin
            drop_cnt_d = 8'd0;
        end else if (bus.uart_out_valid & ~out_ready_s) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Statistics counter registers
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            tx_cnt_q   <= 16'd0;
            rx_cnt_q   <= 16'd0;
            drop_cnt_q <= 8'd0;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_usb_uart_word_buffer.sv
// -----------------------------------------------------------------------------
// tb_usb_uart_word_buffer
// Scoreboard bench: a reference model (posedge) tracks word/byte counts and
// pushes expected bytes/words into queues; a monitor (negedge) compares the
// DUT's flags, levels and data against it. WORD_BYTES=2, TX_DEPTH=16,
// RX_DEPTH=2 so that both FIFO-full corners are reachable.
// -----------------------------------------------------------------------------
module tb_usb_uart_word_buffer;
    localparam int WB  = 2;
    localparam int TXD = 16;
    localparam int RXD = 2;
    localparam int W   = 8 * WB;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    usb_uart_word_buffer_if #(.WORD_BYTES(WB), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) bus ();

`ifdef USB_UART_WORD_BUFFER_STATS_EN
    logic [15:0] tx_bc;
    logic [15:0] rx_bc;
    logic [7:0]  drop_c;
`endif

    usb_uart_word_buffer #(.WORD_BYTES(WB), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk_48mhz     (clk),
        .reset         (reset),
        .bus           (bus)
`ifdef USB_UART_WORD_BUFFER_STATS_EN
        ,
        .tx_byte_count (tx_bc),
        .rx_byte_count (rx_bc),
        .rx_drop_count (drop_c)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- Reference model ----------------
    int           m_tx_words = 0;   // words waiting in the TX FIFO
    int           m_inflight = 0;   // bytes of the loaded word still to send
    int           m_rx_cnt   = 0;   // words in the RX FIFO
    int           m_ai       = 0;   // bytes collected toward the next word
    logic [W-1:0] m_part     = '0;
    logic [15:0]  m_txc      = 16'd0;
    logic [15:0]  m_rxc      = 16'd0;
    logic [7:0]   m_drop     = 8'd0;
    logic [7:0]   tx_exp[$];
    logic [W-1:0] rx_exp[$];

    always @(posedge clk) begin : model
        bit push, hs_in, load, rdy, hs_out, pop;
        if (reset) begin
            m_tx_words = 0; m_inflight = 0; m_rx_cnt = 0; m_ai = 0; m_part = '0;
            m_txc = 16'd0; m_rxc = 16'd0; m_drop = 8'd0;
            tx_exp.delete(); rx_exp.delete();
        end else begin
            push   = bus.tx_valid && (m_tx_words < TXD);
            hs_in  = (m_inflight > 0) && bus.uart_in_ready;
            load   = (m_tx_words > 0) && ((m_inflight == 0) || (hs_in && m_inflight == 1));
            rdy    = (m_rx_cnt < RXD) && !bus.rx_flush;
            hs_out = bus.uart_out_valid && rdy;
            pop    = bus.rx_ready && (m_rx_cnt > 0) && !bus.rx_flush;
            if (push) for (int i = 0; i < WB; i++) tx_exp.push_back(bus.tx_data[8*i +: 8]);
            if (load) m_inflight = WB;
            else if (hs_in) m_inflight--;
            m_tx_words = m_tx_words + int'(push) - int'(load);
            if (hs_in) m_txc++;
            if (hs_out) m_rxc++;
            if (bus.rx_flush) begin
                m_rx_cnt = 0; m_ai = 0; m_part = '0; m_drop = 8'd0;
                rx_exp.delete();
            end else begin
                if (bus.uart_out_valid && !rdy) m_drop++;
                if (pop) m_rx_cnt--;
                if (hs_out) begin
                    m_part[8*m_ai +: 8] = bus.uart_out_data;
                    m_ai++;
                    if (m_ai == WB) begin
                        rx_exp.push_back(m_part);
                        m_rx_cnt++;
                        m_ai = 0;
                    end
                end
            end
        end
    end

    // ---------------- Monitor ----------------
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;

    always @(negedge clk) begin : monitor
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            check("tx_level", 64'(bus.tx_level), 64'(m_tx_words));
            check("tx_ready", 64'(bus.tx_ready), 64'(m_tx_words < TXD));
            check("uart_in_valid", 64'(bus.uart_in_valid), 64'(m_inflight > 0));
            check("rx_level", 64'(bus.rx_level), 64'(m_rx_cnt));
            check("rx_valid", 64'(bus.rx_valid), 64'(m_rx_cnt > 0));
            check("uart_out_ready", 64'(bus.uart_out_ready), 64'((m_rx_cnt < RXD) && !bus.rx_flush));
            if (prev_stall) check("uart_in_hold", 64'(bus.uart_in_data), 64'(prev_data));
            prev_stall = bus.uart_in_valid && !bus.uart_in_ready;
            prev_data  = bus.uart_in_data;
            if (bus.uart_in_valid && bus.uart_in_ready) begin
                check("tx_byte_expected", 64'(tx_exp.size() > 0), 64'(1));
                if (tx_exp.size() > 0) check("uart_in_data", 64'(bus.uart_in_data), 64'(tx_exp.pop_front()));
            end
            if (bus.rx_valid && bus.rx_ready && !bus.rx_flush) begin
                check("rx_word_expected", 64'(rx_exp.size() > 0), 64'(1));
                if (rx_exp.size() > 0) check("rx_data", 64'(bus.rx_data), 64'(rx_exp.pop_front()));
            end
`ifdef USB_UART_WORD_BUFFER_STATS_EN
            check("tx_byte_count", 64'(tx_bc), 64'(m_txc));
            check("rx_byte_count", 64'(rx_bc), 64'(m_rxc));
            check("rx_drop_count", 64'(drop_c), 64'(m_drop));
`endif
        end
    end

    // ---------------- Stimulus ----------------
    task automatic drive(input logic txv, input logic [W-1:0] txd, input logic inr,
                         input logic outv, input logic [7:0] outd, input logic rxr,
                         input logic fl);
        @(posedge clk); #1;
        bus.tx_valid       = txv;
        bus.tx_data        = txd;
        bus.uart_in_ready  = inr;
        bus.uart_out_valid = outv;
        bus.uart_out_data  = outd;
        bus.rx_ready       = rxr;
        bus.rx_flush       = fl;
    endtask

    task automatic random_run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 40) == 0);
        end
    endtask

    logic [7:0] rxb[4];

    initial begin
        bus.tx_valid = 1'b0; bus.tx_data = '0; bus.uart_in_ready = 1'b0;
        bus.uart_out_valid = 1'b0; bus.uart_out_data = 8'd0;
        bus.rx_ready = 1'b0; bus.rx_flush = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_tx_ready", 64'(bus.tx_ready), 64'(1));
        check("rst_rx_valid", 64'(bus.rx_valid), 64'(0));
        check("rst_uart_in_valid", 64'(bus.uart_in_valid), 64'(0));
        check("rst_uart_in_data", 64'(bus.uart_in_data), 64'(0));
        check("rst_uart_out_ready", 64'(bus.uart_out_ready), 64'(1));
        check("rst_rx_data", 64'(bus.rx_data), 64'(0));
        check("rst_tx_level", 64'(bus.tx_level), 64'(0));
        check("rst_rx_level", 64'(bus.rx_level), 64'(0));
        @(posedge clk); #1 reset = 1'b0;

        // TX ordering: two words back to back, sink always ready
        drive(1'b1, 16'hA1B2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 16'hC3D4, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (6) drive(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // RX assembly with the user stalled, then drain
        rxb[0] = 8'h11; rxb[1] = 8'h22; rxb[2] = 8'h33; rxb[3] = 8'h44;
        for (int i = 0; i < 4; i++) drive(1'b0, 16'h0000, 1'b1, 1'b1, rxb[i], 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Backpressure: stream bytes into a 2-deep RX FIFO, then one pop
        for (int i = 0; i < 8; i++) drive(1'b0, 16'h0000, 1'b1, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 8'h70, 1'b1, 1'b0);
        repeat (4) drive(1'b0, 16'h0000, 1'b1, 1'b1, 8'h71, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // TX full and stall pattern 1,0,0,1, then drain
        for (int i = 0; i < 20; i++) drive(1'b1, W'($urandom), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (40) drive(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Flush a partial word, then assemble 0x6655
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic
        random_run(1500);

        // Reset asserted mid-SEND with words pending on both sides
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b1, 16'hBEEF, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        drive(1'b1, 16'h1234, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("midrst_uart_in_valid", 64'(bus.uart_in_valid), 64'(0));
        check("midrst_tx_level", 64'(bus.tx_level), 64'(0));
        check("midrst_rx_level", 64'(bus.rx_level), 64'(0));
        check("midrst_rx_valid", 64'(bus.rx_valid), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        random_run(300);
        repeat (2) drive(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
